// File: rtl/mp_pkg.sv
// -----------------------------------------------------------------------------
// mp_pkg
// Shared definitions for the Green Walker display path: active-low segment
// constants ({g,f,e,d,c,b,a}), the hex-to-segment table, digit/phase counts
// and the glyph-select type used between the controller and the decoder.
// No ports.
// -----------------------------------------------------------------------------
package mp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int NUM_PHASES = 5;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_P     = 7'b0001100;

  typedef enum logic [1:0] {
    SEL_HEX,
    SEL_BLANK,
    SEL_DASH,
    SEL_P
  } seg_sel_e;

  function automatic logic [6:0] hex2seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/mp_seg_decoder.sv
// -----------------------------------------------------------------------------
// mp_seg_decoder
// Combinational glyph decoder for one seven-segment digit (active low).
//   value_i : 4-bit hex value, used when sel_i = SEL_HEX
//   sel_i   : glyph select (hex / blank / dash / letter P)
//   seg_o   : {g,f,e,d,c,b,a}, active low
// -----------------------------------------------------------------------------
module mp_seg_decoder
  import mp_pkg::*;
(
  input  logic [3:0] value_i,
  input  seg_sel_e   sel_i,
  output logic [6:0] seg_o
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    seg_o = SEG_BLANK;
    unique case (sel_i)
      SEL_HEX:   seg_o = hex2seg(value_i);
      SEL_BLANK: seg_o = SEG_BLANK;
      SEL_DASH:  seg_o = SEG_DASH;
      SEL_P:     seg_o = SEG_P;
    endcase
  end

endmodule

// File: rtl/mp_display_controller.sv
// -----------------------------------------------------------------------------
// mp_display_controller
// Drives a time-multiplexed 4-digit common-anode seven-segment display and a
// one-hot phase LED bar from the timer controller's phase/countdown/set flags.
// Digit 3..0 shows: "P", phase (or "-"), blank, hex countdown value.
//
// Parameters: SCAN_DIV (cycles per digit, >= 4), BLANK_CYC (anti-ghost blank
//             window at slot start, < SCAN_DIV), BLINK_DIV (blink half-period).
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   set            : set mode (dp on digit 0, editable digits blink)
//   cur_phase[2:0] : phase number, 0..4 valid
//   seven_num[3:0] : countdown / setting value
//   an[3:0]        : digit anodes, active low
//   seg[6:0]       : {g,f,e,d,c,b,a}, active low
//   dp             : decimal point, active low
//   phase_led[4:0] : one-hot phase, active high
// Build option: define MP_DISP_BLINK_EN to blink digits 0 and 2 in set mode;
// without it set mode is shown by the decimal point only.
// -----------------------------------------------------------------------------
module mp_display_controller
  import mp_pkg::*;
#(
  parameter int SCAN_DIV  = 25000,
  parameter int BLANK_CYC = 16,
  parameter int BLINK_DIV = 6250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic [2:0] cur_phase,
  input  logic [3:0] seven_num,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic [4:0] phase_led
);

  localparam int SCAN_W = $clog2(SCAN_DIV);

  // Input registers
  logic       set_q;
  logic [2:0] phase_q;
  logic [3:0] num_q;

  // Scan state
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]        dig_idx_q, dig_idx_d;

  // Output registers
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [4:0] phase_led_q, phase_led_d;

  seg_sel_e   sel;
  logic [3:0] value;

`ifdef MP_DISP_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_DIV);
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;

  always_comb begin
    blink_cnt_d = '0;
    blink_on_d  = 1'b1;
    if (set_q) begin
      if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = !blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blink_on_d  = blink_on_q;
      end
    end
  end
`endif

  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    dig_idx_d  = dig_idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      dig_idx_d  = dig_idx_q + 2'd1;
    end

    // Glyph for the digit currently selected by dig_idx_q; an and seg are both
    // derived from this same state so they switch on the same edge.
    value = num_q;
    sel   = SEL_BLANK;
    case (dig_idx_q)
      2'd0: sel = SEL_HEX;
      2'd1: sel = SEL_BLANK;
      2'd2: begin
        value = {1'b0, phase_q};
        sel   = (phase_q < 3'(NUM_PHASES)) ? SEL_HEX : SEL_DASH;
      end
      default: sel = SEL_P;
    endcase
`ifdef MP_DISP_BLINK_EN
    if (set_q && !blink_on_q && (dig_idx_q == 2'd0 || dig_idx_q == 2'd2)) begin
      sel = SEL_BLANK;
    end
`endif

    an_d        = (scan_cnt_q < SCAN_W'(BLANK_CYC)) ? 4'b1111 : ~(4'b0001 << dig_idx_q);
    dp_d        = !(set_q && dig_idx_q == 2'd0);
    phase_led_d = (phase_q < 3'(NUM_PHASES)) ? (5'b00001 << phase_q) : 5'b00000;
  end

  mp_seg_decoder u_seg_decoder (
    .value_i (value),
    .sel_i   (sel),
    .seg_o   (seg_d)
  );

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, so it only takes effect while
    // the clock is running.
    if (rst) begin
      set_q       <= 1'b0;
      phase_q     <= '0;
      num_q       <= '0;
      scan_cnt_q  <= '0;
      dig_idx_q   <= '0;
      an_q        <= 4'b1111;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      phase_led_q <= '0;
`ifdef MP_DISP_BLINK_EN
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
`endif
    end else begin
      set_q       <= set;
      phase_q     <= cur_phase;
      num_q       <= seven_num;
      scan_cnt_q  <= scan_cnt_d;
      dig_idx_q   <= dig_idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      phase_led_q <= phase_led_d;
`ifdef MP_DISP_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
`endif
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign phase_led = phase_led_q;

endmodule

// File: tb/tb_mp_display_controller.sv
// -----------------------------------------------------------------------------
// tb_mp_display_controller
// Self-checking bench: a cycle-level behavioural model (scan position from the
// number of cycles since reset, blink phase from the length of the current
// set-mode run) predicts an/seg/dp/phase_led every cycle; directed sequences
// add literal expectations for reset, content, invalid phase, blink and
// reset mid-scan, followed by randomized inputs.
// -----------------------------------------------------------------------------
module tb_mp_display_controller;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BD = 16;

  localparam logic [6:0] BLANK = 7'b1111111;

`ifdef MP_DISP_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set = 1'b0;
  logic [2:0] cur_phase = '0;
  logic [3:0] seven_num = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [4:0] phase_led;

  mp_display_controller #(
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC),
    .BLINK_DIV (BD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .set       (set),
    .cur_phase (cur_phase),
    .seven_num (seven_num),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .phase_led (phase_led)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct {
    int n;    // cycles since reset
    bit s;    // registered set
    int ph;   // registered phase
    int num;  // registered value
    int run;  // consecutive registered-set cycles ending here
    bit bon;  // blink visible
  } st_t;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  st_t        m;
  st_t        nx;
  bit         started = 1'b0;
  bit         e_rst;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [4:0] e_led;

  function automatic logic [6:0] content(input st_t s);
    int dig;
    logic [6:0] g;
    dig = (s.n / SD) % 4;
    case (dig)
      0: g = hex_tab[s.num];
      1: g = BLANK;
      2: g = (s.ph < 5) ? hex_tab[s.ph] : 7'b0111111;
      default: g = 7'b0001100;
    endcase
    if (BLINK && s.s && !s.bon && (dig == 0 || dig == 2)) g = BLANK;
    return g;
  endfunction

  always @(posedge clk) begin
    int dig;
    started = 1'b1;
    e_rst   = rst;
    if (rst) begin
      e_an  = 4'b1111;
      e_seg = BLANK;
      e_dp  = 1'b1;
      e_led = 5'b0;
      m     = '{n: 0, s: 1'b0, ph: 0, num: 0, run: 0, bon: 1'b1};
    end else begin
      dig   = (m.n / SD) % 4;
      e_an  = ((m.n % SD) < BC) ? 4'b1111 : ~(4'b0001 << dig);
      e_seg = content(m);
      e_dp  = !(m.s && dig == 0);
      e_led = (m.ph < 5) ? (5'b00001 << m.ph) : 5'b0;
      nx.n   = m.n + 1;
      nx.s   = set;
      nx.ph  = int'(cur_phase);
      nx.num = int'(seven_num);
      nx.run = set ? m.run + 1 : 0;
      nx.bon = ((m.run / BD) % 2) == 0;
      m = nx;
    end
  end

  // Compare process: every cycle, away from the active edge.
  int blank_run = 0;
  bit tainted   = 1'b1;

  always @(negedge clk) begin
    if (started) begin
      check("an", an, e_an);
      check("phase_led", phase_led, e_led);
      if (e_an != 4'b1111) begin
        check("seg", seg, e_seg);
        check("dp", dp, e_dp);
      end
      check("an_onehot", ($countones(~an) <= 1), 1);
      if (an == 4'b1111) begin
        blank_run++;
      end else begin
        if (blank_run > 0 && !tainted) check("blank_window", blank_run, BC);
        blank_run = 0;
        tainted   = 1'b0;
      end
      if (e_rst) tainted = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed + random stimulus
  // ---------------------------------------------------------------------------
  task automatic wait_an(input logic [3:0] target, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (an !== target && cyc < 200);
    check("wait_an", an, target);
  endtask

  initial begin
    int c;
    logic [6:0] exp_seg;

    // Reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, BLANK);
    check("rst_dp", dp, 1'b1);
    check("rst_led", phase_led, 5'b0);
    rst       = 1'b0;
    seven_num = 4'd5;
    wait_an(4'b1110, c);
    check("first_active_cycle", c, BC + 1);
    check("dig0_five", seg, 7'b0010010);
    check("led_phase0", phase_led, 5'b00001);

    // Phase LED latency
    cur_phase = 3'd2;
    @(negedge clk);
    check("led_lat1", phase_led, 5'b00001);
    @(negedge clk);
    check("led_lat2", phase_led, 5'b00100);

    // Content of each digit
    wait_an(4'b1101, c);
    check("dig1_blank", seg, BLANK);
    wait_an(4'b1011, c);
    check("dig2_two", seg, 7'b0100100);
    wait_an(4'b0111, c);
    check("dig3_p", seg, 7'b0001100);

    // Invalid phase
    cur_phase = 3'd6;
    wait_an(4'b1110, c);
    wait_an(4'b1011, c);
    check("dig2_dash", seg, 7'b0111111);
    check("led_invalid", phase_led, 5'b0);

    // Set mode / blink, aligned to the start of a digit-0 slot
    cur_phase = 3'd1;
    wait_an(4'b1110, c);
    set       = 1'b1;
    seven_num = 4'd15;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k >= 2 && an == 4'b1110) begin
        exp_seg = (BLINK && k >= BD + 2 && k <= 2 * BD + 1) ? BLANK : 7'b0001110;
        check("blink_seg", seg, exp_seg);
        check("blink_dp", dp, 1'b0);
      end
    end

    // Leave set mode
    set = 1'b0;
    repeat (40) @(negedge clk);
    wait_an(4'b1110, c);
    check("unset_dp", dp, 1'b1);
    check("unset_seg", seg, 7'b0001110);

    // Randomized inputs, occasional set toggles and resets
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      seven_num = 4'($urandom);
      cur_phase = 3'($urandom);
      if ($urandom_range(0, 39) == 0) set = !set;
      rst = ($urandom_range(0, 149) == 0);
    end
    rst = 1'b0;
    set = 1'b0;
    repeat (4 * SD) @(negedge clk);

    // Reset mid-scan while digit 2 is active
    wait_an(4'b1011, c);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_an", an, 4'b1111);
    check("midrst_seg", seg, BLANK);
    check("midrst_dp", dp, 1'b1);
    check("midrst_led", phase_led, 5'b0);
    rst = 1'b0;
    wait_an(4'b1110, c);
    check("midrst_resume_cycle", c, BC + 1);

    repeat (2 * SD) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
